pixel_serializer: RTL and testbench

Downstream stage of the colour LUT. Takes one batch of `NUM_ENGINES` parallel RGB values per handshake and emits them one pixel per cycle as a valid/ready video stream. It tags each pixel with start-of-frame and end-of-line markers using internal x/y raster counters. It sits between the LUT output and the video output / DMA packer.

---
 rtl/pixel_serializer.sv | 115 +++++++++++
 tb/tb_pixel_serializer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pixel_serializer.sv
// Serialises one batch of NUM_ENGINES parallel pixels per handshake into a
// one-pixel-per-cycle valid/ready stream tagged with SOF/EOL raster markers.
module pixel_serializer #(
    parameter int unsigned RBG_SIZE    = 24,
    parameter int unsigned NUM_ENGINES = 8,
    parameter int unsigned X_SIZE      = 640,
    parameter int unsigned Y_SIZE      = 480
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [RBG_SIZE-1:0] rgb_val [NUM_ENGINES-1:0],
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RBG_SIZE-1:0] out_data,
    output logic                out_sof,
    output logic                out_eol,
    output logic                frame_done
);

    localparam int unsigned IDX_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam int unsigned X_W   = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
    localparam int unsigned Y_W   = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENGINES - 1);
    localparam logic [X_W-1:0]   X_LAST   = X_W'(X_SIZE - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(Y_SIZE - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [RBG_SIZE-1:0] batch_q [NUM_ENGINES-1:0];
    logic [RBG_SIZE-1:0] batch_d [NUM_ENGINES-1:0];
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic                frame_done_q, frame_done_d;

    logic out_xfer;
    logic in_xfer;
    logic last_pix;

    // Everything the stream presents is decoded from held state, so out_ready
    // only ever reaches in_ready combinationally.
    assign out_valid  = (state_q == DRAIN);
    assign out_data   = batch_q[idx_q];
    assign out_sof    = out_valid && (x_q == '0) && (y_q == '0);
    assign out_eol    = out_valid && (x_q == X_LAST);
    assign frame_done = frame_done_q;

    assign last_pix = (idx_q == LAST_IDX);
    assign out_xfer = out_valid && out_ready;
    assign in_ready = !reset && ((state_q == EMPTY) || (out_xfer && last_pix));
    assign in_xfer  = in_valid && in_ready;

    // Next-state: drain index, raster position and batch reload.
    always_comb begin
        state_d      = state_q;
        batch_d      = batch_q;
        idx_d        = idx_q;
        x_d          = x_q;
        y_d          = y_q;
        frame_done_d = 1'b0;

        if (out_xfer) begin
            if (last_pix) begin
                state_d = EMPTY;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end

            if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == Y_LAST) begin
                    y_d          = '0;
                    frame_done_d = 1'b1;
                end else begin
                    y_d = y_q + Y_W'(1);
                end
            end else begin
                x_d = x_q + X_W'(1);
            end
        end

        // A new batch overrides the drain-complete transition for a bubble-free handoff.
        if (in_xfer) begin
            batch_d = rgb_val;
            idx_d   = '0;
            state_d = DRAIN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= EMPTY;
            batch_q      <= '{default: '0};
            idx_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            batch_q      <= batch_d;
            idx_q        <= idx_d;
            x_q          <= x_d;
            y_q          <= y_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_pixel_serializer.sv
// Directed + randomized bench for pixel_serializer; a pixel queue and a linear
// frame position serve as the reference for stream content and markers.
module tb_pixel_serializer;

    localparam int unsigned W  = 24;
    localparam int unsigned N  = 8;
    localparam int unsigned XS = 16;
    localparam int unsigned YS = 2;
    localparam int unsigned FRAME = XS * YS;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] rgb_val [N-1:0];
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_sof;
    logic         out_eol;
    logic         frame_done;

    pixel_serializer #(
        .RBG_SIZE   (W),
        .NUM_ENGINES(N),
        .X_SIZE     (XS),
        .Y_SIZE     (YS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rgb_val   (rgb_val),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sof   (out_sof),
        .out_eol   (out_eol),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] exp_q [$];
    int           pos         = 0;
    logic         fd_exp      = 1'b0;
    logic         after_reset = 1'b0;
    int           fd_seen     = 0;
    int           xfers       = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_random();
        for (int i = 0; i < N; i++) rgb_val[i] = W'($urandom);
    endtask

    task automatic load_ramp();
        for (int i = 0; i < N; i++) rgb_val[i] = W'(i);
    endtask

    // One clock: drive, check against the model just after the falling edge, advance model.
    task automatic cyc(input logic iv, input logic ordy, input logic rst);
        logic exp_ov, exp_ir, in_x, out_x, fd_next;
        reset     = rst;
        in_valid  = iv;
        out_ready = ordy;
        #1;
        exp_ov = (exp_q.size() != 0);
        exp_ir = !rst && (exp_q.size() == 0 || (ordy && exp_q.size() == 1));
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        chk("in_ready", 32'(in_ready), 32'(exp_ir));
        chk("frame_done", 32'(frame_done), 32'(fd_exp));
        if (frame_done === 1'b1) fd_seen++;
        if (after_reset) chk("out_data_reset", 32'(out_data), 32'd0);
        if (exp_ov) begin
            chk("out_data", 32'(out_data), 32'(exp_q[0]));
            chk("out_sof", 32'(out_sof), 32'(pos == 0));
            chk("out_eol", 32'(out_eol), 32'((pos % XS) == XS - 1));
        end else begin
            chk("out_sof_idle", 32'(out_sof), 32'd0);
            chk("out_eol_idle", 32'(out_eol), 32'd0);
        end
        in_x    = iv && exp_ir;
        out_x   = exp_ov && ordy && !rst;
        fd_next = out_x && (pos == FRAME - 1);
        if (out_x) begin
            void'(exp_q.pop_front());
            pos = (pos + 1) % FRAME;
            xfers++;
        end
        if (in_x) for (int i = 0; i < N; i++) exp_q.push_back(rgb_val[i]);
        after_reset = rst;
        if (rst) begin
            exp_q.delete();
            pos     = 0;
            fd_next = 1'b0;
        end
        fd_exp = fd_next;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        load_random();
        @(posedge clk);
        @(negedge clk);
        exp_q.delete();
        after_reset = 1'b1;

        // Reset holds everything idle even with a batch offered.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1);

        // Single ramp batch then drain to empty.
        load_ramp();
        cyc(1'b1, 1'b1, 1'b0);
        load_random();
        for (int i = 0; i < N + 2; i++) cyc(1'b0, 1'b1, 1'b0);

        // Full frame back-to-back from a clean frame start, spilling into the next frame.
        cyc(1'b0, 1'b1, 1'b1);
        fd_seen = 0;
        for (int i = 0; i < FRAME + N + 1; i++) begin
            load_random();
            cyc(1'b1, 1'b1, 1'b0);
        end
        for (int i = 0; i < N + 1; i++) cyc(1'b0, 1'b1, 1'b0);
        chk("frame_done_count", 32'(fd_seen), 32'd1);

        // Random backpressure with a long stall on the last pixel of each batch.
        for (int b = 0; b < 6; b++) begin
            for (int k = 0; k < 60 && exp_q.size() != 1; k++) begin
                load_random();
                cyc(1'($urandom), 1'($urandom), 1'b0);
            end
            chk("reached_last_pixel", 32'(exp_q.size()), 32'd1);
            for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 1'b0);
            load_random();
            cyc(1'b1, 1'b1, 1'b0);
        end
        for (int k = 0; k < 3 * N; k++) cyc(1'b0, 1'b1, 1'b0);

        // Starvation between batches: raster position carries across the gap.
        cyc(1'b0, 1'b1, 1'b1);
        load_random();
        cyc(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < N; k++) cyc(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) cyc(1'b0, 1'b1, 1'b0);
        chk("pos_after_gap", 32'(pos), 32'(N));
        load_random();
        cyc(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < N + 1; k++) cyc(1'b0, 1'b1, 1'b0);

        // Reset after 20 pixels restarts the frame.
        cyc(1'b0, 1'b1, 1'b1);
        xfers = 0;
        for (int k = 0; k < 60 && xfers < 20; k++) begin
            load_random();
            cyc(1'b1, 1'b1, 1'b0);
        end
        chk("pixels_before_reset", 32'(xfers), 32'd20);
        cyc(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 2 * N + 1; k++) begin
            load_random();
            cyc(k < N + 1 ? 1'b1 : 1'b0, 1'b1, 1'b0);
        end
        for (int k = 0; k < N; k++) cyc(1'b0, 1'b1, 1'b0);
        chk("pos_after_restart", 32'(pos), 32'(2 * N));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
